// File: rtl/free_list.sv
// Physical register free list for the rename stage.
// A circular FIFO of free physical register indices. Rename pops from the head, commit pushes
// stale registers at the tail, and a branch mispredict rewinds the head to a BRAT checkpoint.
module free_list #(
  parameter int unsigned PREG_W = 6,
  parameter int unsigned PTR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pop_req,
  output logic [PREG_W-1:0] p_dest,
  output logic              free_list_read_ack,
  input  logic              push_valid,
  input  logic [PREG_W-1:0] push_preg,
  input  logic              flush_by_branch,
  input  logic [PTR_W:0]    restore_head_ptr,
  output logic [PTR_W:0]    head_ptr,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic              overflow
);

  localparam int unsigned DEPTH = 2 ** PTR_W;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  localparam logic [PTR_W:0] PtrOne  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0] TailRst = {1'b1, {PTR_W{1'b0}}};

  logic [PREG_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    head_q, head_d;
  logic [PTR_W:0]    tail_q, tail_d;
  logic              overflow_q, overflow_d;
  logic              full;
  logic              push_nz;
  logic              push_en;

  // Status, head read-out, pop handshake and next-state pointer arithmetic.
  always_comb begin
    empty              = (head_q == tail_q);
    full               = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) &&
                         (head_q[PTR_W] != tail_q[PTR_W]);
    count              = tail_q - head_q;
    p_dest             = mem_q[head_q[PTR_W-1:0]];
    free_list_read_ack = pop_req & ~empty & ~flush_by_branch;
    head_ptr           = head_q;
    overflow           = overflow_q;

    // x0 is never renamed, so a zero push carries no register to free.
    push_nz = push_valid & (push_preg != '0);
    push_en = push_nz & ~full;

    head_d = head_q;
    if (flush_by_branch) begin
      head_d = restore_head_ptr;
    end else if (free_list_read_ack) begin
      head_d = head_q + PtrOne;
    end

    // Committed frees survive a flush, so the tail ignores flush_by_branch.
    tail_d = tail_q;
    if (push_en) begin
      tail_d = tail_q + PtrOne;
    end

    overflow_d = overflow_q | (push_nz & full);
  end

  // Pointer and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= TailRst;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; reset fills it with the physical registers not mapped by the initial RAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PREG_W'(DEPTH + i);
      end
    end else if (push_en) begin
      mem_q[tail_q[PTR_W-1:0]] <= push_preg;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed vectors, a queue-based reference model compared
// every cycle, plus hand-computed literal checks on key scenarios.
module tb_free_list;

  logic       clk;
  logic       rst;
  logic       pop_req;
  logic [5:0] p_dest;
  logic       free_list_read_ack;
  logic       push_valid;
  logic [5:0] push_preg;
  logic       flush_by_branch;
  logic [5:0] restore_head_ptr;
  logic [5:0] head_ptr;
  logic       empty;
  logic [5:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: every register ever placed in the list, in order; m_head is an absolute
  // position into that history, so the tail is simply its length.
  int m_log[$];
  int m_head;
  bit m_ovf;

  free_list #(.PREG_W(6), .PTR_W(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .pop_req            (pop_req),
    .p_dest             (p_dest),
    .free_list_read_ack (free_list_read_ack),
    .push_valid         (push_valid),
    .push_preg          (push_preg),
    .flush_by_branch    (flush_by_branch),
    .restore_head_ptr   (restore_head_ptr),
    .head_ptr           (head_ptr),
    .empty              (empty),
    .count              (count),
    .overflow           (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int m_count();
    return m_log.size() - m_head;
  endfunction

  task automatic model_reset();
    m_log = {};
    for (int i = 0; i < 32; i++) m_log.push_back(32 + i);
    m_head = 0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle of inputs, compare the DUT against the model mid-cycle, then advance
  // the model at the clock edge. rabs is the absolute model head to restore on flush.
  task automatic cyc(input bit pop, input bit push, input int pv, input bit fl, input int rabs);
    bit exp_ack;
    bit m_full;
    pop_req          = pop;
    push_valid       = push;
    push_preg        = 6'(pv);
    flush_by_branch  = fl;
    restore_head_ptr = 6'(rabs);
    @(negedge clk);
    exp_ack = pop && (m_count() != 0) && !fl;
    m_full  = (m_count() == 32);
    chk("ack", int'(free_list_read_ack), int'(exp_ack));
    chk("empty", int'(empty), int'(m_count() == 0));
    chk("count", int'(count), m_count());
    chk("head_ptr", int'(head_ptr), m_head % 64);
    chk("overflow", int'(overflow), int'(m_ovf));
    if (m_count() != 0) chk("p_dest", int'(p_dest), m_log[m_head]);
    @(posedge clk);
    if (fl) m_head = rabs;
    else if (exp_ack) m_head++;
    if (push && pv != 0) begin
      if (m_full) m_ovf = 1'b1;
      else m_log.push_back(pv);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst              = 1'b1;
    pop_req          = 1'b0;
    push_valid       = 1'b0;
    push_preg        = '0;
    flush_by_branch  = 1'b0;
    restore_head_ptr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Post-reset state.
    chk("rst_count", int'(count), 32);
    chk("rst_pdest", int'(p_dest), 32);
    chk("rst_empty", int'(empty), 0);
    chk("rst_ack", int'(free_list_read_ack), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_head", int'(head_ptr), 0);

    // Push while full: dropped, overflow sticks.
    cyc(0, 1, 45, 0, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 32);
    cyc(0, 0, 0, 0, 0);
    chk("ovf_sticky", int'(overflow), 1);

    // Three pops from reset.
    do_reset();
    chk("ovf_clr", int'(overflow), 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("pop3_pdest", int'(p_dest), 34);
    cyc(1, 0, 0, 0, 0);
    chk("pop3_count", int'(count), 29);
    chk("pop3_head", int'(head_ptr), 3);
    // Zero push is ignored.
    cyc(0, 1, 0, 0, 0);
    chk("x0_count", int'(count), 29);

    // Checkpoint at head 2, pop to 7, flush with a concurrent pop request.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("ckpt_head", int'(head_ptr), 2);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
    chk("pre_flush_head", int'(head_ptr), 7);
    cyc(1, 0, 0, 1, 2);
    chk("flush_pdest", int'(p_dest), 34);
    chk("flush_count", int'(count), 30);
    chk("flush_head", int'(head_ptr), 2);

    // Drain to empty, pop on empty, then push-while-empty with no bypass.
    do_reset();
    for (int i = 0; i < 32; i++) cyc(1, 0, 0, 0, 0);
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);
    cyc(1, 0, 0, 0, 0);
    chk("empty_pop_head", int'(head_ptr), 32);
    cyc(1, 1, 40, 0, 0);
    chk("nobypass_pdest", int'(p_dest), 40);
    pop_req = 1'b1;
    #1;
    chk("nobypass_ack", int'(free_list_read_ack), 1);
    cyc(1, 0, 0, 0, 0);
    chk("nobypass_empty", int'(empty), 1);

    // Wrap: 40 simultaneous pop/push pairs after making room.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 40; k++) cyc(1, 1, k, 0, 0);
    chk("wrap_count", int'(count), 28);
    chk("wrap_head", int'(head_ptr), 44);
    chk("wrap_bit", int'(head_ptr[5]), 1);
    chk("wrap_pdest", int'(p_dest), 13);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);

    // Reset asserted between clock edges takes effect at once.
    #2;
    rst = 1'b1;
    #1;
    chk("async_count", int'(count), 32);
    chk("async_head", int'(head_ptr), 0);
    chk("async_pdest", int'(p_dest), 32);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
